// File: rtl/bexkat1_bus_arbiter_pkg.sv
// bexkat1_bus_arbiter_pkg: arbiter state encoding and grant codes shared by the bus arbiter files
package bexkat1_bus_arbiter_pkg;
    typedef enum logic [1:0] {S_IDLE, S_INS, S_DAT, S_DONE} arb_state_t;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_INS  = 2'b01;
    localparam logic [1:0] GNT_DAT  = 2'b10;
endpackage

// File: rtl/bexkat1_bus_arbiter_if.sv
// if_wb: Wishbone classic bus bundle
//  master drives cyc/stb/we/sel/adr/dat_m, slave drives dat_s/ack
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/bexkat1_bus_watchdog.sv
// bexkat1_bus_watchdog: counts unacknowledged bus cycles and flags a hung slave
//  clk, rst_n : clock, async active-low reset
//  clear      : zero the count (new grant or slave ack)
//  enable     : count this cycle (granted with bus.cyc high)
//  ack        : slave ack this cycle; suppresses expiry
//  expire     : count reached TIMEOUT-1 with no ack this cycle
module bexkat1_bus_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expire
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expire = enable && !ack && count == LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else
            count <= (clear || ack) ? '0 : (enable && count != LAST) ? count + 1'b1 : count;
endmodule

// File: rtl/bexkat1_bus_arbiter.sv
// bexkat1_bus_arbiter: shares one Wishbone master port between fetch (ins) and mem stage (dat)
//  clk_i, rst_ni : clock, async active-low reset
//  ins, dat      : requester ports (arbiter is their slave)
//  bus           : shared downstream Wishbone master port
//  grant_o       : registered owner, 01 ins, 10 dat, 00 idle
//  timeout_o     : one-cycle pulse when the watchdog terminates a cycle
module bexkat1_bus_arbiter
    import bexkat1_bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT      = 256,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] TO_DATA      = 32'hffffffff
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    if_wb.slave        ins,
    if_wb.slave        dat,
    if_wb.master       bus,
    output logic [1:0] grant_o,
    output logic       timeout_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    arb_state_t    state;
    logic [SW-1:0] starve;
    logic          pend_ins, pend_dat;
    logic          own_ins, own_dat, to_ins, to_dat;
    logic          ins_ack, dat_ack, starved, expire;

    assign own_ins = state == S_INS;
    assign own_dat = state == S_DAT;
    // the synthetic ack is delivered in the first S_DONE cycle, to whoever held the grant
    assign to_ins  = timeout_o && grant_o == GNT_INS;
    assign to_dat  = timeout_o && grant_o == GNT_DAT;
    assign starved = ins.cyc && starve == SMAX;

    assign bus.cyc   = own_ins ? ins.cyc : own_dat ? dat.cyc : 1'b0;
    assign bus.stb   = own_ins ? ins.stb | pend_ins : own_dat ? dat.stb | pend_dat : 1'b0;
    assign bus.we    = own_ins ? ins.we : own_dat ? dat.we : 1'b0;
    assign bus.sel   = own_ins ? ins.sel : own_dat ? dat.sel : '0;
    assign bus.adr   = own_ins ? ins.adr : own_dat ? dat.adr : '0;
    assign bus.dat_m = own_ins ? ins.dat_m : own_dat ? dat.dat_m : '0;

    assign ins_ack   = (own_ins && bus.ack) || to_ins;
    assign dat_ack   = (own_dat && bus.ack) || to_dat;
    assign ins.ack   = ins_ack;
    assign dat.ack   = dat_ack;
    assign ins.dat_s = own_ins ? bus.dat_s : to_ins ? TO_DATA : '0;
    assign dat.dat_s = own_dat ? bus.dat_s : to_dat ? TO_DATA : '0;

    bexkat1_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .clear  (state == S_IDLE),
        .enable ((own_ins || own_dat) && bus.cyc),
        .ack    (bus.ack),
        .expire (expire)
    );

    // a strobe seen while held off is remembered until that transfer is acked or cyc drops
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            pend_ins <= 1'b0;
            pend_dat <= 1'b0;
        end else begin
            pend_ins <= ins.cyc && (pend_ins || ins.stb) && !ins_ack;
            pend_dat <= dat.cyc && (pend_dat || dat.stb) && !dat_ack;
        end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state     <= S_IDLE;
            grant_o   <= GNT_NONE;
            timeout_o <= 1'b0;
            starve    <= '0;
        end else begin
            timeout_o <= expire;
            case (state)
                S_IDLE:
                    if (dat.cyc && !starved) begin
                        state   <= S_DAT;
                        grant_o <= GNT_DAT;
                        if (ins.cyc && starve != SMAX)
                            starve <= starve + 1'b1;
                    end else if (ins.cyc) begin
                        state   <= S_INS;
                        grant_o <= GNT_INS;
                        starve  <= '0;
                    end
                S_INS, S_DAT:
                    if (expire)
                        state <= S_DONE;
                    else if (!bus.cyc) begin
                        state   <= S_IDLE;
                        grant_o <= GNT_NONE;
                    end
                S_DONE:
                    if (!(grant_o == GNT_INS ? ins.cyc : dat.cyc)) begin
                        state   <= S_IDLE;
                        grant_o <= GNT_NONE;
                    end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_bexkat1_bus_arbiter.sv
// tb_bexkat1_bus_arbiter: directed self-checking bench for bexkat1_bus_arbiter (TIMEOUT=8)
module tb_bexkat1_bus_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] grant_o;
    logic       timeout_o;
    int         total = 0;
    int         passed = 0;

    if_wb ins_if ();
    if_wb dat_if ();
    if_wb bus_if ();

    bexkat1_bus_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(4), .TO_DATA(32'hffffffff)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ins       (ins_if),
        .dat       (dat_if),
        .bus       (bus_if),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic half();
        @(negedge clk_i);
    endtask

    initial begin
        {ins_if.cyc, ins_if.stb, ins_if.we} = 3'b000;
        {dat_if.cyc, dat_if.stb, dat_if.we} = 3'b000;
        ins_if.sel = 4'h0; ins_if.adr = '0; ins_if.dat_m = '0;
        dat_if.sel = 4'h0; dat_if.adr = '0; dat_if.dat_m = '0;
        bus_if.ack = 1'b0; bus_if.dat_s = '0;
        next();
        half();
        check("rst_grant", {30'd0, grant_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_bus_cyc", {31'd0, bus_if.cyc}, 32'd0);
        check("rst_bus_adr", bus_if.adr, 32'd0);
        check("rst_ins_ack", {31'd0, ins_if.ack}, 32'd0);
        check("rst_dat_dat_s", dat_if.dat_s, 32'd0);
        next();
        rst_ni = 1'b1;
        next();

        // 1: fetch alone, slave acks two cycles after strobe
        ins_if.cyc = 1'b1; ins_if.stb = 1'b1; ins_if.sel = 4'hf; ins_if.adr = 32'h100;
        half();
        check("t1_holdoff_grant", {30'd0, grant_o}, 32'd0);
        check("t1_holdoff_cyc", {31'd0, bus_if.cyc}, 32'd0);
        next();
        half();
        check("t1_grant", {30'd0, grant_o}, 32'd1);
        check("t1_bus_stb", {31'd0, bus_if.stb}, 32'd1);
        check("t1_bus_adr", bus_if.adr, 32'h100);
        check("t1_bus_sel", {28'd0, bus_if.sel}, 32'hf);
        next();
        next();
        bus_if.ack = 1'b1; bus_if.dat_s = 32'hdeadbeef;
        half();
        check("t1_ins_ack", {31'd0, ins_if.ack}, 32'd1);
        check("t1_ins_dat_s", ins_if.dat_s, 32'hdeadbeef);
        check("t1_dat_ack", {31'd0, dat_if.ack}, 32'd0);
        check("t1_dat_dat_s", dat_if.dat_s, 32'd0);
        next();
        bus_if.ack = 1'b0; bus_if.dat_s = '0;
        ins_if.cyc = 1'b0; ins_if.stb = 1'b0;
        half();
        check("t1_drop_cyc", {31'd0, bus_if.cyc}, 32'd0);
        next();
        half();
        check("t1_release", {30'd0, grant_o}, 32'd0);

        // 2: simultaneous request, dat first, one dead cycle, then ins
        next();
        ins_if.cyc = 1'b1; ins_if.stb = 1'b1; ins_if.adr = 32'h200;
        dat_if.cyc = 1'b1; dat_if.stb = 1'b1; dat_if.we = 1'b1; dat_if.sel = 4'h3;
        dat_if.adr = 32'h300; dat_if.dat_m = 32'hcafe0001;
        next();
        half();
        check("t2_grant_dat", {30'd0, grant_o}, 32'd2);
        check("t2_bus_adr", bus_if.adr, 32'h300);
        check("t2_bus_we", {31'd0, bus_if.we}, 32'd1);
        check("t2_bus_dat_m", bus_if.dat_m, 32'hcafe0001);
        next();
        bus_if.ack = 1'b1; bus_if.dat_s = 32'h55aa55aa;
        half();
        check("t2_dat_ack", {31'd0, dat_if.ack}, 32'd1);
        check("t2_ins_ack", {31'd0, ins_if.ack}, 32'd0);
        check("t2_ins_dat_s", ins_if.dat_s, 32'd0);
        next();
        bus_if.ack = 1'b0; bus_if.dat_s = '0;
        dat_if.cyc = 1'b0; dat_if.stb = 1'b0; dat_if.we = 1'b0;
        next();
        half();
        check("t2_dead_grant", {30'd0, grant_o}, 32'd0);
        check("t2_dead_cyc", {31'd0, bus_if.cyc}, 32'd0);
        next();
        half();
        check("t2_grant_ins", {30'd0, grant_o}, 32'd1);
        check("t2_ins_adr", bus_if.adr, 32'h200);
        check("t2_ins_stb", {31'd0, bus_if.stb}, 32'd1);
        next();
        ins_if.cyc = 1'b0; ins_if.stb = 1'b0;
        next();

        // 3: dat back-to-back with ins held: dat x4 then ins
        ins_if.cyc = 1'b1; ins_if.stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dat_if.cyc = 1'b1; dat_if.stb = 1'b1;
            next();
            half();
            check($sformatf("t3_dat_win_%0d", k), {30'd0, grant_o}, 32'd2);
            next();
            dat_if.cyc = 1'b0; dat_if.stb = 1'b0;
            next();
        end
        dat_if.cyc = 1'b1; dat_if.stb = 1'b1;
        next();
        half();
        check("t3_ins_wins", {30'd0, grant_o}, 32'd1);
        next();
        ins_if.cyc = 1'b0; ins_if.stb = 1'b0;
        next();
        next();
        half();
        check("t3_dat_after", {30'd0, grant_o}, 32'd2);
        next();
        dat_if.cyc = 1'b0; dat_if.stb = 1'b0;
        next();

        // 4: slave never acks, watchdog terminates 8 cycles after grant
        dat_if.cyc = 1'b1; dat_if.stb = 1'b1;
        next();
        for (int k = 0; k < 8; k++) begin
            half();
            if (k == 0) check("t4_grant", {30'd0, grant_o}, 32'd2);
            if (k == 7) check("t4_no_early_to", {31'd0, timeout_o}, 32'd0);
            next();
        end
        half();
        check("t4_timeout", {31'd0, timeout_o}, 32'd1);
        check("t4_dat_ack", {31'd0, dat_if.ack}, 32'd1);
        check("t4_dat_dat_s", dat_if.dat_s, 32'hffffffff);
        check("t4_bus_cyc", {31'd0, bus_if.cyc}, 32'd0);
        check("t4_ins_ack", {31'd0, ins_if.ack}, 32'd0);
        next();
        half();
        check("t4_to_once", {31'd0, timeout_o}, 32'd0);
        check("t4_ack_once", {31'd0, dat_if.ack}, 32'd0);
        check("t4_done_cyc", {31'd0, bus_if.cyc}, 32'd0);
        dat_if.cyc = 1'b0; dat_if.stb = 1'b0;
        next();
        half();
        check("t4_idle", {30'd0, grant_o}, 32'd0);

        // 5: real ack on the expiry cycle wins
        next();
        ins_if.cyc = 1'b1; ins_if.stb = 1'b1; ins_if.adr = 32'h400;
        next();
        repeat (7) next();
        bus_if.ack = 1'b1; bus_if.dat_s = 32'h12345678;
        half();
        check("t5_ins_ack", {31'd0, ins_if.ack}, 32'd1);
        check("t5_ins_dat_s", ins_if.dat_s, 32'h12345678);
        next();
        bus_if.ack = 1'b0; bus_if.dat_s = '0;
        ins_if.cyc = 1'b0; ins_if.stb = 1'b0;
        half();
        check("t5_no_timeout", {31'd0, timeout_o}, 32'd0);
        check("t5_no_extra_ack", {31'd0, ins_if.ack}, 32'd0);
        next();

        // 6: asynchronous reset during a data cycle
        dat_if.cyc = 1'b1; dat_if.stb = 1'b1; dat_if.adr = 32'h500;
        next();
        half();
        check("t6_busy", {31'd0, bus_if.cyc}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_cyc", {31'd0, bus_if.cyc}, 32'd0);
        check("t6_rst_grant", {30'd0, grant_o}, 32'd0);
        dat_if.cyc = 1'b0; dat_if.stb = 1'b0;
        next();
        rst_ni = 1'b1;
        next();
        ins_if.cyc = 1'b1; ins_if.stb = 1'b1; ins_if.adr = 32'h600;
        next();
        half();
        check("t6_fresh_grant", {30'd0, grant_o}, 32'd1);
        check("t6_fresh_adr", bus_if.adr, 32'h600);
        next();
        bus_if.ack = 1'b1; bus_if.dat_s = 32'h0badf00d;
        half();
        check("t6_fresh_ack", {31'd0, ins_if.ack}, 32'd1);
        check("t6_fresh_dat_s", ins_if.dat_s, 32'h0badf00d);
        next();
        bus_if.ack = 1'b0;
        ins_if.cyc = 1'b0; ins_if.stb = 1'b0;
        next();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
